// File: rtl/ds2_pkg.sv
// Shared types and constants for the DualShock pad reader: FSM states,
// command bytes, phase lengths and the PS2-to-SNES button mapping.
package ds2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP,
    HOLD,
    COMMIT
  } state_e;

  localparam int NUM_BYTES = 5;

  localparam logic [7:0] CMD_START = 8'h01;
  localparam logic [7:0] CMD_POLL  = 8'h42;
  localparam logic [7:0] CMD_IDLE  = 8'h00;
  localparam logic [7:0] SIGNATURE = 8'h5A;

  // Phase lengths in SCK half-periods.
  localparam int SETUP_HP = 4;
  localparam int GAP_HP   = 4;
  localparam int HOLD_HP  = 2;

  // PS2 button bit positions (active low on the wire).
  localparam int PS_SELECT = 0;
  localparam int PS_START  = 3;
  localparam int PS_UP     = 4;
  localparam int PS_RIGHT  = 5;
  localparam int PS_DOWN   = 6;
  localparam int PS_LEFT   = 7;
  localparam int PS_L1     = 2;
  localparam int PS_R1     = 3;
  localparam int PS_TRI    = 4;
  localparam int PS_CIRCLE = 5;
  localparam int PS_CROSS  = 6;
  localparam int PS_SQUARE = 7;

  // SNES button word bit positions.
  localparam int SNES_B      = 0;
  localparam int SNES_Y      = 1;
  localparam int SNES_SELECT = 2;
  localparam int SNES_START  = 3;
  localparam int SNES_UP     = 4;
  localparam int SNES_DOWN   = 5;
  localparam int SNES_LEFT   = 6;
  localparam int SNES_RIGHT  = 7;
  localparam int SNES_A      = 8;
  localparam int SNES_X      = 9;
  localparam int SNES_L      = 10;
  localparam int SNES_R      = 11;

  typedef struct packed {
    logic        ok;
    logic [15:0] buttons;
  } pad_result_t;

  function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return CMD_START;
      3'd1:    return CMD_POLL;
      default: return CMD_IDLE;
    endcase
  endfunction

  function automatic pad_result_t decode_pad(input logic [7:0] sig,
                                             input logic [7:0] lo,
                                             input logic [7:0] hi);
    pad_result_t r;
    logic [7:0]  pl;
    logic [7:0]  ph;
    r  = '0;
    pl = ~lo;
    ph = ~hi;
    if (sig == SIGNATURE) begin
      r.ok                   = 1'b1;
      r.buttons[SNES_B]      = ph[PS_CROSS];
      r.buttons[SNES_Y]      = ph[PS_SQUARE];
      r.buttons[SNES_SELECT] = pl[PS_SELECT];
      r.buttons[SNES_START]  = pl[PS_START];
      r.buttons[SNES_UP]     = pl[PS_UP];
      r.buttons[SNES_DOWN]   = pl[PS_DOWN];
      r.buttons[SNES_LEFT]   = pl[PS_LEFT];
      r.buttons[SNES_RIGHT]  = pl[PS_RIGHT];
      r.buttons[SNES_A]      = ph[PS_CIRCLE];
      r.buttons[SNES_X]      = ph[PS_TRI];
      r.buttons[SNES_L]      = ph[PS_L1];
      r.buttons[SNES_R]      = ph[PS_R1];
    end
    return r;
  endfunction

endpackage

// File: rtl/ds2_spi_byte.sv
// One mode-3, LSB-first byte exchange. start_i launches the first SCK fall;
// done_o is high on the edge that ends the last bit's high half.
module ds2_spi_byte #(
  parameter int CLK_DIV = 54
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] tx_byte_i,
  input  logic       miso_i,
  output logic       sck_o,
  output logic       mosi_o,
  output logic [7:0] rx_byte_o,
  output logic       done_o
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic             active_q;
  logic             high_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic             sck_q;
  logic             mosi_q;
  logic [7:0]       tx_q;
  logic [7:0]       rx_q;
  logic             half_end;

  assign half_end  = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign done_o    = active_q & high_q & half_end & (bit_q == 3'd7);
  assign sck_o     = sck_q;
  assign mosi_o    = mosi_q;
  assign rx_byte_o = rx_q;

  // NOTE: every register here uses <= so all of them see pre-edge values;
  // blocking assignments would let rx_q/sck_q ordering change behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q <= 1'b0;
      high_q   <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      sck_q    <= 1'b1;
      mosi_q   <= 1'b1;
      tx_q     <= '0;
      rx_q     <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      high_q   <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      sck_q    <= 1'b0;
      mosi_q   <= tx_byte_i[0];
      tx_q     <= tx_byte_i;
    end else if (active_q) begin
      if (half_end) begin
        cnt_q <= '0;
        if (!high_q) begin
          // Rising SCK edge: the pad's bit has been stable for a half-period.
          sck_q  <= 1'b1;
          high_q <= 1'b1;
          rx_q   <= {miso_i, rx_q[7:1]};
        end else if (bit_q == 3'd7) begin
          active_q <= 1'b0;
          high_q   <= 1'b0;
          mosi_q   <= 1'b1;
        end else begin
          bit_q  <= bit_q + 3'd1;
          high_q <= 1'b0;
          sck_q  <= 1'b0;
          mosi_q <= tx_q[bit_q + 3'd1];
        end
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ds2_pad_reader.sv
// Periodic DualShock poller: poll timer, five-byte sequencer and SNES decode.
// Outputs change only in COMMIT, so a consumer never sees a partial word.
module ds2_pad_reader
  import ds2_pkg::*;
#(
  parameter int CLK_DIV     = 54,
  parameter int POLL_CYCLES = 450000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ds_cs_n,
  output logic        ds_sck,
  output logic        ds_mosi,
  input  logic        ds_miso,
  output logic [15:0] snes_buttons,
  output logic        pad_ok,
  output logic        update
);

  localparam int TIMER_W   = $clog2(POLL_CYCLES);
  localparam int SETUP_CYC = SETUP_HP * CLK_DIV;
  localparam int GAP_CYC   = GAP_HP * CLK_DIV;
  localparam int HOLD_CYC  = HOLD_HP * CLK_DIV;
  localparam int WAIT_MAX  = (SETUP_CYC > GAP_CYC) ?
                             ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                             ((GAP_CYC > HOLD_CYC) ? GAP_CYC : HOLD_CYC);
  localparam int WAIT_W    = $clog2(WAIT_MAX);

  state_e             state_q;
  logic [TIMER_W-1:0] timer_q;
  logic               poll_pending_q;
  logic               poll_pending_d;
  logic [WAIT_W-1:0]  wait_q;
  logic [2:0]         byte_q;
  logic [7:0]         sig_q;
  logic [7:0]         lo_q;
  logic [7:0]         hi_q;
  logic               cs_n_q;
  logic [15:0]        buttons_q;
  logic               pad_ok_q;
  logic               update_q;

  logic               tick;
  logic               spi_start;
  logic               spi_done;
  logic [7:0]         spi_rx;
  pad_result_t        pad_res;

  assign tick = (timer_q == TIMER_W'(POLL_CYCLES - 1));

  // A tick while busy stays latched until IDLE consumes it; repeats merge.
  assign poll_pending_d = tick | (poll_pending_q & (state_q != IDLE));

  assign spi_start = ((state_q == SETUP) && (wait_q == WAIT_W'(SETUP_CYC - 1))) ||
                     ((state_q == GAP)   && (wait_q == WAIT_W'(GAP_CYC - 1)));

  assign pad_res = decode_pad(sig_q, lo_q, hi_q);

  ds2_spi_byte #(
    .CLK_DIV (CLK_DIV)
  ) u_spi (
    .clk       (clk),
    .rst       (rst),
    .start_i   (spi_start),
    .tx_byte_i (cmd_byte(byte_q)),
    .miso_i    (ds_miso),
    .sck_o     (ds_sck),
    .mosi_o    (ds_mosi),
    .rx_byte_o (spi_rx),
    .done_o    (spi_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q        <= '0;
      poll_pending_q <= 1'b0;
    end else begin
      timer_q        <= tick ? '0 : timer_q + TIMER_W'(1);
      poll_pending_q <= poll_pending_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      byte_q    <= '0;
      sig_q     <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      cs_n_q    <= 1'b1;
      buttons_q <= '0;
      pad_ok_q  <= 1'b0;
      update_q  <= 1'b0;
    end else begin
      update_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (poll_pending_q) begin
            cs_n_q  <= 1'b0;
            wait_q  <= '0;
            byte_q  <= '0;
            state_q <= SETUP;
          end
        end
        SETUP, GAP: begin
          if (spi_start) state_q <= SHIFT;
          else           wait_q  <= wait_q + WAIT_W'(1);
        end
        SHIFT: begin
          if (spi_done) begin
            case (byte_q)
              3'd1:    sig_q <= spi_rx;
              3'd2:    lo_q  <= spi_rx;
              3'd3:    hi_q  <= spi_rx;
              default: ;
            endcase
            wait_q <= '0;
            if (byte_q == 3'(NUM_BYTES - 1)) begin
              cs_n_q  <= 1'b1;
              state_q <= HOLD;
            end else begin
              byte_q  <= byte_q + 3'd1;
              state_q <= GAP;
            end
          end
        end
        HOLD: begin
          if (wait_q == WAIT_W'(HOLD_CYC - 1)) state_q <= COMMIT;
          else                                 wait_q  <= wait_q + WAIT_W'(1);
        end
        COMMIT: begin
          buttons_q <= pad_res.buttons;
          pad_ok_q  <= pad_res.ok;
          update_q  <= 1'b1;
          byte_q    <= '0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ds_cs_n      = cs_n_q;
  assign snes_buttons = buttons_q;
  assign pad_ok       = pad_ok_q;
  assign update       = update_q;

endmodule

// File: tb/tb_ds2_pad_reader.sv
// Bench for ds2_pad_reader: a pad model answers each poll from a vector table,
// expected words go through a scoreboard queue and are checked on each update.
module tb_ds2_pad_reader;

  localparam int CLK_DIV     = 2;
  localparam int POLL_CYCLES = 400;
  localparam int FIRST_CS    = POLL_CYCLES + 1;
  localparam int LATENCY     = 102 * CLK_DIV + 1;
  localparam int NV          = 8;

  typedef struct packed {
    logic [7:0]  id;
    logic [7:0]  sig;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [15:0] btn;
    logic        ok;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ds_miso = 1'b1;
  logic        ds_cs_n;
  logic        ds_sck;
  logic        ds_mosi;
  logic [15:0] snes_buttons;
  logic        pad_ok;
  logic        update;

  int n_checks = 0;
  int n_pass   = 0;

  vec_t vecs [NV];
  vec_t exp_q [$];

  always #5 clk = ~clk;

  ds2_pad_reader #(
    .CLK_DIV     (CLK_DIV),
    .POLL_CYCLES (POLL_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ds_cs_n      (ds_cs_n),
    .ds_sck       (ds_sck),
    .ds_mosi      (ds_mosi),
    .ds_miso      (ds_miso),
    .snes_buttons (snes_buttons),
    .pad_ok       (pad_ok),
    .update       (update)
  );

  // Pad model: shifts the response out on SCK falls, records MOSI on SCK rises.
  logic [7:0]  resp [5];
  logic [39:0] mosi_cap = '0;
  int          bit_cnt  = 0;
  logic        cs_prev  = 1'b1;
  logic        sck_prev = 1'b1;

  always @(ds_sck or ds_cs_n) begin
    if (ds_cs_n !== cs_prev) begin
      if (!ds_cs_n) begin
        bit_cnt  = 0;
        mosi_cap = '0;
      end else begin
        ds_miso = 1'b1;
      end
    end
    if (ds_sck !== sck_prev && !rst && !ds_cs_n && bit_cnt < 40) begin
      if (!ds_sck) begin
        ds_miso = resp[bit_cnt / 8][bit_cnt % 8];
      end else begin
        mosi_cap[bit_cnt] = ds_mosi;
        bit_cnt++;
      end
    end
    cs_prev  = ds_cs_n;
    sck_prev = ds_sck;
  end

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic load_resp(input vec_t v);
    resp[0] = v.id;
    resp[1] = v.sig;
    resp[2] = v.lo;
    resp[3] = v.hi;
    resp[4] = 8'hFF;
  endtask

  task automatic wait_cs_fall(output int n);
    n = 0;
    while (ds_cs_n && n < 2000) begin
      @(posedge clk);
      n++;
      #1;
    end
    if (ds_cs_n) check("cs_fall_timeout", 40'd1, 40'd0);
  endtask

  task automatic wait_update(output int n);
    n = 0;
    while (!update && n < 1000) begin
      @(posedge clk);
      n++;
      #1;
    end
    if (!update) check("update_timeout", 40'd0, 40'd1);
  endtask

  task automatic score(input string tag);
    vec_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected_update"}, 40'd1, 40'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_buttons"}, 40'(snes_buttons), 40'(e.btn));
      check({tag, "_pad_ok"}, 40'(pad_ok), 40'(e.ok));
      check({tag, "_mosi"}, mosi_cap, 40'h00_0000_4201);
    end
  endtask

  initial begin
    int   n;
    int   k;
    vec_t abort_v;

    //            id     sig    lo     hi     buttons   ok
    vecs[0] = '{8'h41, 8'h5A, 8'hFF, 8'hBF, 16'h0001, 1'b1};
    vecs[1] = '{8'h41, 8'h5A, 8'hE7, 8'hFF, 16'h0018, 1'b1};
    vecs[2] = '{8'h41, 8'h5A, 8'h00, 8'h00, 16'h0FFF, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'h0000, 1'b0};
    vecs[4] = '{8'h73, 8'h5A, 8'h7E, 8'hF3, 16'h0C44, 1'b1};
    vecs[5] = '{8'h41, 8'h5B, 8'h00, 8'h00, 16'h0000, 1'b0};
    vecs[6] = '{8'h41, 8'h5A, 8'hF9, 8'hFC, 16'h0000, 1'b1};
    vecs[7] = '{8'h41, 8'h5A, 8'hDF, 8'h5F, 16'h0182, 1'b1};
    abort_v = vecs[4];

    load_resp(vecs[0]);
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", 40'(ds_cs_n), 40'd1);
    check("rst_sck", 40'(ds_sck), 40'd1);
    check("rst_mosi", 40'(ds_mosi), 40'd1);
    check("rst_buttons", 40'(snes_buttons), 40'd0);
    check("rst_pad_ok", 40'(pad_ok), 40'd0);
    check("rst_update", 40'(update), 40'd0);

    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      load_resp(vecs[i]);
      exp_q.push_back(vecs[i]);
      wait_cs_fall(n);
      if (i == 0) begin
        check("first_cs_fall", 40'(n), 40'(FIRST_CS));
      end else begin
        check("poll_gap", 40'(n), 40'(POLL_CYCLES - LATENCY - 1));
        check("hold_between", 40'(snes_buttons), 40'(vecs[i-1].btn));
      end
      wait_update(n);
      check("update_latency", 40'(n), 40'(LATENCY));
      score($sformatf("vec%0d", i));
      @(posedge clk);
      #1;
      check("update_width", 40'(update), 40'd0);
    end

    // Reset in the middle of byte 2, then a clean poll afterwards.
    load_resp(abort_v);
    wait_cs_fall(n);
    k = 0;
    while (bit_cnt < 20 && k < 500) begin
      @(posedge clk);
      k++;
    end
    #1;
    rst = 1'b1;
    #1;
    check("abort_cs_n", 40'(ds_cs_n), 40'd1);
    check("abort_sck", 40'(ds_sck), 40'd1);
    check("abort_mosi", 40'(ds_mosi), 40'd1);
    check("abort_buttons", 40'(snes_buttons), 40'd0);
    check("abort_pad_ok", 40'(pad_ok), 40'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    exp_q.push_back(abort_v);
    wait_cs_fall(n);
    check("post_rst_cs_fall", 40'(n), 40'(FIRST_CS));
    wait_update(n);
    check("post_rst_latency", 40'(n), 40'(LATENCY));
    score("post_rst");
    check("scoreboard_empty", 40'(exp_q.size()), 40'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
